weighted_rr_arbiter: RTL and testbench

Parametrised N-way arbiter with weighted round-robin and fixed-priority modes. It grants one requester at a time as a registered one-hot vector. In weighted mode the winner keeps the grant for up to `weight` consecutive cycles before the round-robin pointer moves on. It sits in front of shared resources (bus ports, memory banks) and supersedes the plain equal-share round-robin arbiter wherever requesters need unequal bandwidth.

---
 rtl/weighted_rr_arbiter_if.sv | 15 +
 rtl/weighted_rr_arbiter.sv | 63 ++++++
 tb/tb_weighted_rr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/weighted_rr_arbiter_if.sv
// weighted_rr_arbiter_if: request/weight/grant bundle between requesters and the arbiter
interface weighted_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int WW = 4
);
  localparam int IW = $clog2(N);
  logic [N-1:0]    request;
  logic [N*WW-1:0] weight;
  logic            prio_mode;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            grant_valid;
  modport master (output request, weight, prio_mode, input grant, grant_id, grant_valid);
  modport slave  (input request, weight, prio_mode, output grant, grant_id, grant_valid);
endinterface

// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: N-way weighted round-robin / fixed-priority arbiter with registered one-hot grant
module weighted_rr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input logic clk,
  input logic rst_n,
  weighted_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] NL = (IW+1)'(N);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d, ptr_q, ptr_d, win;
  logic [WW-1:0]   credit_q, credit_d, win_w;
  logic            found, hold;
  logic [IW:0]     j;
  // circular search from ptr (or from 0 in fixed-priority mode); first set request wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    win_w = '0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = (bus.prio_mode ? '0 : {1'b0, ptr_q}) + (IW+1)'(i);
      j = j >= NL ? j - NL : j;
      if (!found && bus.request[j[IW-1:0]]) begin
        found = 1'b1;
        win   = j[IW-1:0];
        win_w = bus.weight[j[IW-1:0]*WW +: WW];
      end
    end
  end
  // owner holds while it keeps requesting and has credit left; otherwise take the search winner
  always_comb begin
    hold       = !bus.prio_mode && state_q == BURST && bus.request[grant_id_q] && credit_q > WW'(1);
    state_d    = hold || found ? BURST : IDLE;
    grant_d    = hold ? grant_q : found ? N'(1) << win : '0;
    grant_id_d = hold ? grant_id_q : found ? win : '0;
    credit_d   = hold ? credit_q - WW'(1) : found ? (win_w == '0 ? WW'(1) : win_w) : credit_q;
    ptr_d      = hold || !found || bus.prio_mode ? ptr_q : (win == IW'(N-1) ? '0 : win + IW'(1));
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      credit_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
    end
  end
  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = state_q == BURST;
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter: directed plus random stimulus against a behavioural arbitration model
module tb_weighted_rr_arbiter;
  localparam int N  = 4;
  localparam int WW = 4;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  int m_owner, m_ptr, m_credit;
  int seq_ids[$] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
  weighted_rr_arbiter_if #(.N(N), .WW(WW)) bus ();
  weighted_rr_arbiter #(.N(N), .WW(WW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int wt(input int w);
    return int'((bus.weight >> (w*WW)) & ((1 << WW) - 1));
  endfunction
  task automatic step();
    int w;
    if (!rst_n) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_credit = 0;
    end else if (!bus.prio_mode && m_owner >= 0 && bus.request[m_owner] && m_credit > 1) begin
      m_credit--;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = bus.prio_mode ? k : (m_ptr + k) % N;
        if (w < 0 && bus.request[i]) w = i;
      end
      m_owner = w;
      if (w >= 0) begin
        m_credit = wt(w) == 0 ? 1 : wt(w);
        if (!bus.prio_mode) m_ptr = (w + 1) % N;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("grant", bus.grant, m_owner < 0 ? 0 : 1 << m_owner);
    chk("grant_id", bus.grant_id, m_owner < 0 ? 0 : m_owner);
    chk("grant_valid", bus.grant_valid, m_owner >= 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n         = 1'b0;
    bus.request   = 4'hf;
    bus.weight    = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.prio_mode = 1'b0;
    m_owner = -1; m_ptr = 0; m_credit = 0;
    repeat (3) begin
      step();
      chk("rst_grant", bus.grant, 0);
      chk("rst_valid", bus.grant_valid, 0);
    end
    rst_n = 1'b1;
    step();
    chk("first_grant", bus.grant, 4'b0001);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("rr_equal", bus.grant, 1 << (k % 4));
    end
    do_reset();
    bus.weight = {4'd1, 4'd2, 4'd1, 4'd3};
    foreach (seq_ids[k]) begin
      step();
      chk("rr_weighted", bus.grant, 1 << seq_ids[k]);
    end
    do_reset();
    bus.weight  = {4'd1, 4'd1, 4'd1, 4'd4};
    bus.request = 4'b0011;
    repeat (3) begin
      step();
      chk("early_drop_hold", bus.grant, 4'b0001);
    end
    bus.request = 4'b0010;
    step();
    chk("early_drop_next", bus.grant, 4'b0010);
    bus.weight  = {4'd1, 4'd0, 4'd1, 4'd1};
    bus.request = 4'b0100;
    repeat (5) begin
      step();
      chk("w0_sole_grant", bus.grant, 4'b0100);
      chk("w0_sole_id", bus.grant_id, 2);
    end
    bus.prio_mode = 1'b1;
    bus.request   = 4'b1010;
    repeat (3) begin
      step();
      chk("prio_grant", bus.grant, 4'b0010);
    end
    bus.prio_mode = 1'b0;
    bus.weight    = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.request   = 4'b1111;
    step();
    chk("resume_ptr", bus.grant_id, 3);
    bus.weight  = {4'd1, 4'd1, 4'd1, 4'd3};
    bus.request = 4'b0001;
    step();
    chk("burst_start", bus.grant, 4'b0001);
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_burst", bus.grant, 4'b0000);
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) bus.request = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus.weight = $urandom_range(0, 7) == 0 ? 16'hffff : 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.prio_mode = ~bus.prio_mode;
      rst_n = $urandom_range(0, 99) != 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
